// File: rtl/button_conditioner.sv
// -----------------------------------------------------------------------------
// button_conditioner
//
// Purpose:
//    Input-side conditioner for the raw board push-buttons. Each button is
//    synchronised to CLK100MHZ and debounced. The block then produces a clean
//    level, single-cycle press/release pulses and a priority-encoded selection
//    event. The LED blink-speed control logic consumes btn_press / sel_*
//    rather than the raw pins.
//
// Ports:
//    CLK100MHZ    in   1       system clock, 100 MHz
//    ck_rst       in   1       asynchronous reset, active-low
//    btn          in   N_BTN   raw asynchronous buttons, 1 = pressed
//    btn_level    out  N_BTN   debounced button state
//    btn_press    out  N_BTN   1-cycle pulse per accepted 0->1 (and per auto-repeat)
//    btn_release  out  N_BTN   1-cycle pulse per accepted 1->0
//    sel_valid    out  1       1-cycle pulse, some btn_press bit was set last cycle
//    sel_idx      out  2       lowest index among those bits, held between events
//
// Configuration macro:
//    BTN_AUTOREPEAT_EN  when defined, a held button re-fires btn_press after
//                       REPEAT_DELAY cycles and then every REPEAT_PERIOD cycles.
//                       When undefined, no repeat logic exists and each accepted
//                       press gives exactly one btn_press pulse.
// -----------------------------------------------------------------------------
module button_conditioner #(
   parameter int N_BTN           = 4,
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int REPEAT_DELAY    = 50000000,
   parameter int REPEAT_PERIOD   = 10000000
) (
   input  logic             CLK100MHZ,
   input  logic             ck_rst,
   input  logic [N_BTN-1:0] btn,
   output logic [N_BTN-1:0] btn_level,
   output logic [N_BTN-1:0] btn_press,
   output logic [N_BTN-1:0] btn_release,
   output logic             sel_valid,
   output logic [1:0]       sel_idx
);

   localparam int            CW      = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);

`ifdef BTN_AUTOREPEAT_EN
   localparam int            REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int            RW      = $clog2(REP_MAX + 1);
   localparam logic [RW-1:0] REP_DLY = RW'(REPEAT_DELAY);
   localparam logic [RW-1:0] REP_PER = RW'(REPEAT_PERIOD);
`else
   // The repeat parameters are kept in the parameter list so both builds
   // share one interface; they are only referenced here.
   if (REPEAT_DELAY < 0 || REPEAT_PERIOD < 1) begin : g_repeat_params_ignored
   end
`endif

   genvar gi;
   generate
      for (gi = 0; gi < N_BTN; gi++) begin : g_btn
         logic          s1_reg;
         logic          s2_reg;
         logic [CW-1:0] cnt_reg;
         logic          level_reg;
         logic          press_reg;
         logic          release_reg;
         logic          accept;
         logic          rep_fire;

         // The new synchronised level has been stable long enough. It is taken
         // on this edge.
         assign accept = (s2_reg != level_reg) && (cnt_reg == DB_LAST);

         always_ff @(posedge CLK100MHZ or negedge ck_rst) begin
            if (!ck_rst) begin
               s1_reg      <= 1'b0;
               s2_reg      <= 1'b0;
               cnt_reg     <= '0;
               level_reg   <= 1'b0;
               press_reg   <= 1'b0;
               release_reg <= 1'b0;
            end else begin
               s1_reg <= btn[gi];
               s2_reg <= s1_reg;

               // A glitch back to the accepted level wipes any partial count.
               if (s2_reg == level_reg || accept)
                  cnt_reg <= '0;
               else
                  cnt_reg <= cnt_reg + 1'b1;

               if (accept)
                  level_reg <= s2_reg;

               // The pulses are registered on the same edge as level_reg. This way
               // they line up with the first cycle that shows the new level.
               press_reg   <= (accept & s2_reg) | rep_fire;
               release_reg <= accept & ~s2_reg;
            end
         end

`ifdef BTN_AUTOREPEAT_EN
         logic [RW-1:0] rep_cnt_reg;
         logic          rep_first_reg;

         // rep_cnt_reg holds the number of edges since the last press/repeat
         // pulse. It fires on REPEAT_DELAY for the first repeat and on
         // REPEAT_PERIOD afterwards. The edge that accepts a release never fires.
         assign rep_fire = level_reg && !accept &&
                           (rep_cnt_reg == (rep_first_reg ? REP_DLY : REP_PER));

         always_ff @(posedge CLK100MHZ or negedge ck_rst) begin
            if (!ck_rst) begin
               rep_cnt_reg   <= '0;
               rep_first_reg <= 1'b0;
            end else if (accept && s2_reg) begin
               rep_cnt_reg   <= RW'(1);
               rep_first_reg <= 1'b1;
            end else if (!level_reg || accept) begin
               rep_cnt_reg   <= '0;
               rep_first_reg <= 1'b0;
            end else if (rep_fire) begin
               rep_cnt_reg   <= RW'(1);
               rep_first_reg <= 1'b0;
            end else begin
               rep_cnt_reg   <= rep_cnt_reg + 1'b1;
            end
         end
`else
         assign rep_fire = 1'b0;
`endif

         assign btn_level[gi]   = level_reg;
         assign btn_press[gi]   = press_reg;
         assign btn_release[gi] = release_reg;
      end
   endgenerate

   // Priority encoder: the loop scans downward, so the lowest set bit is the
   // last one written and wins.
   logic [1:0] low_idx;
   always_comb begin
      low_idx = 2'd0;
      for (int i = N_BTN - 1; i >= 0; i--) begin
         if (btn_press[i])
            low_idx = 2'(i);
      end
   end

   logic       sel_valid_reg;
   logic [1:0] sel_idx_reg;

   always_ff @(posedge CLK100MHZ or negedge ck_rst) begin
      if (!ck_rst) begin
         sel_valid_reg <= 1'b0;
         sel_idx_reg   <= 2'd0;
      end else begin
         sel_valid_reg <= |btn_press;
         if (|btn_press)
            sel_idx_reg <= low_idx;
      end
   end

   assign sel_valid = sel_valid_reg;
   assign sel_idx   = sel_idx_reg;

endmodule

// File: tb/tb_button_conditioner.sv
// -----------------------------------------------------------------------------
// tb_button_conditioner
//
// Directed bench for button_conditioner. It uses DEBOUNCE_CYCLES=8,
// REPEAT_DELAY=20 and REPEAT_PERIOD=5. Each edge step gives the press/release
// pulses expected on that edge. Level, sel_valid and sel_idx follow from them.
// -----------------------------------------------------------------------------
module tb_button_conditioner;

   logic       CLK100MHZ = 1'b0;
   logic       ck_rst;
   logic [3:0] btn;
   logic [3:0] btn_level;
   logic [3:0] btn_press;
   logic [3:0] btn_release;
   logic       sel_valid;
   logic [1:0] sel_idx;

   int n_vec = 0;
   int n_err = 0;

   logic [3:0] exp_level;
   logic [1:0] exp_idx;
   logic [3:0] prev_prs;

`ifdef BTN_AUTOREPEAT_EN
   localparam bit AUTO_REPEAT = 1'b1;
`else
   localparam bit AUTO_REPEAT = 1'b0;
`endif

   button_conditioner #(
      .N_BTN          (4),
      .DEBOUNCE_CYCLES(8),
      .REPEAT_DELAY   (20),
      .REPEAT_PERIOD  (5)
   ) dut (
      .CLK100MHZ  (CLK100MHZ),
      .ck_rst     (ck_rst),
      .btn        (btn),
      .btn_level  (btn_level),
      .btn_press  (btn_press),
      .btn_release(btn_release),
      .sel_valid  (sel_valid),
      .sel_idx    (sel_idx)
   );

   always #5 CLK100MHZ = ~CLK100MHZ;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [1:0] lowest(input logic [3:0] v);
      logic [1:0] r;
      r = 2'd0;
      for (int i = 3; i >= 0; i--)
         if (v[i]) r = 2'(i);
      return r;
   endfunction

   // Advance one rising edge, then sample 1 time unit after it.
   // {level, press, release, sel_valid, sel_idx} is compared as one vector.
   task automatic step(input string tag, input logic [3:0] prs, input logic [3:0] rel);
      logic exp_sv;
      @(posedge CLK100MHZ);
      #1;
      exp_sv = (prev_prs != 4'd0);
      if (exp_sv) exp_idx = lowest(prev_prs);
      exp_level = (exp_level | prs) & ~rel;
      check(tag, {17'd0, btn_level, btn_press, btn_release, sel_valid, sel_idx},
                 {17'd0, exp_level, prs, rel, exp_sv, exp_idx});
      $display("edge %s: btn=%b lvl=%b prs=%b rel=%b sv=%b idx=%0d",
               tag, btn, btn_level, btn_press, btn_release, sel_valid, sel_idx);
      prev_prs = prs;
   endtask

   task automatic quiet(input string tag, input int n);
      for (int k = 0; k < n; k++) step(tag, 4'd0, 4'd0);
   endtask

   task automatic clear_model();
      exp_level = 4'd0;
      exp_idx   = 2'd0;
      prev_prs  = 4'd0;
   endtask

   initial begin
      clear_model();
      ck_rst = 1'b0;
      btn    = 4'hF;

      // 1: reset holds everything low despite active buttons
      quiet("rst_hold", 20);
      btn    = 4'h0;
      ck_rst = 1'b1;
      quiet("rst_rel", 12);

      // 2: btn[2] press, 10-edge latency, selection one edge later
      btn[2] = 1'b1;
      quiet("b2_wait", 9);
      step("b2_press", 4'b0100, 4'b0000);
      quiet("b2_sel", 2);
      btn[2] = 1'b0;
      quiet("b2_rwait", 9);
      step("b2_release", 4'b0000, 4'b0100);
      quiet("b2_idle", 3);

      // 3: btn[0] bounces every 3 cycles, then settles high
      btn[0] = 1'b1;
      for (int t = 0; t < 10; t++) begin
         quiet("b0_bounce", 3);
         btn[0] = ~btn[0];
      end
      btn[0] = 1'b1;
      quiet("b0_wait", 9);
      step("b0_press", 4'b0001, 4'b0000);
      quiet("b0_sel", 2);
      btn[0] = 1'b0;
      quiet("b0_rwait", 9);
      step("b0_release", 4'b0000, 4'b0001);
      quiet("b0_nosel", 3);

      // 4: btn[1] and btn[3] together, btn[1] wins the selection
      btn = 4'b1010;
      quiet("b13_wait", 9);
      step("b13_press", 4'b1010, 4'b0000);
      quiet("b13_sel", 2);
      btn = 4'b0000;
      quiet("b13_rwait", 9);
      step("b13_release", 4'b0000, 4'b1010);
      quiet("b13_idle", 3);

      // 5: reset during a press when the debounce count is 5
      btn[1] = 1'b1;
      quiet("b1_count", 7);
      ck_rst = 1'b0;
      clear_model();
      quiet("b1_inrst", 3);
      ck_rst = 1'b1;
      quiet("b1_wait", 9);
      step("b1_press", 4'b0010, 4'b0000);
      quiet("b1_sel", 2);
      btn[1] = 1'b0;
      quiet("b1_rwait", 9);
      step("b1_release", 4'b0000, 4'b0010);
      quiet("b1_idle", 3);

      // 6: btn[3] held for 60 cycles. The press lands on edge 10 and the
      // release on edge 70. Auto-repeat adds pulses on edges 30, 35, ... 65.
      btn[3] = 1'b1;
      for (int e = 1; e <= 75; e++) begin
         logic [3:0] prs;
         logic [3:0] rel;
         prs = 4'd0;
         rel = 4'd0;
         if (e == 10) prs = 4'b1000;
         if (AUTO_REPEAT && e >= 30 && e < 70 && ((e - 30) % 5) == 0) prs = 4'b1000;
         if (e == 70) rel = 4'b1000;
         step("b3_hold", prs, rel);
         if (e == 60) btn[3] = 1'b0;
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
